fadd_pipe: RTL
==============

Name: fadd_pipe

Overview:
Pipelined, parametrised IEEE-754-style floating-point adder/subtractor and the successor to the single-cycle combinational fadd. It takes two operands plus an add/sub mode and produces a round-to-nearest-even result after a fixed 3-cycle latency. A valid/ready handshake stalls the whole pipeline on output backpressure. It sits in the FPU datapath between the operand register read and the FP writeback.

Parameters:
EXP_W, 8, exponent field width (legal 5..11)
MAN_W, 23, stored mantissa width, hidden bit excluded (legal 10..52)
W, EXP_W+MAN_W+1, derived operand width; not overridden

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
in_valid  in  1  operand set valid
in_ready  out  1  pipeline accepts operands this cycle
x1  in  W  operand A {sign, exp, man}
x2  in  W  operand B
sub  in  1  1: compute x1 - x2 (sign of x2 inverted before processing)
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
y  out  W  result
ovf  out  1  result overflowed to infinity from finite inputs
unf  out  1  nonzero result flushed to zero
nan  out  1  result is canonical NaN

Behaviour:
- One clock. Reset is asynchronous and active-low. While rstn=0, all stage valids, out_valid, y, ovf, unf and nan are 0.
- Reset mid-operation discards all in-flight results. No result from before the reset ever appears at the output.
- Global enable en = !out_valid || out_ready. in_ready = en, driven combinationally.
- Transfer in: in_valid && in_ready. Transfer out: out_valid && out_ready.
- When en=0, every stage register holds its value, including y and the flags. Order is preserved and nothing is dropped or duplicated.
- Bubbles advance whenever en=1. Latency is exactly 3 cycles from accept to out_valid when there is no stall. Throughput is 1 result per cycle.
- Stage 1 (unpack/align):
  - Apply sub to the x2 sign.
  - Flush subnormal inputs (exp=0) to signed zero.
  - Choose the larger-magnitude operand by full {exp, man} compare, not by exponent only.
  - Shift right the smaller operand by the exponent difference, saturated at MAN_W+3.
  - Keep guard and round bits; OR all shifted-out bits into sticky.
- Stage 2 (add): add the mantissas when effective signs are equal, otherwise subtract (larger - smaller). The datapath is MAN_W+4 bits plus a carry bit.
- Stage 3 (normalise/round/pack):
  - On carry out, shift right 1 and increment the exponent, keeping sticky.
  - Otherwise, leading-zero count and shift left.
  - Round to nearest, ties to even, using guard, round, sticky and the lsb.
  - If rounding carries out, renormalise and increment the exponent.
- Result rules:
  - Exponent >= all-ones after rounding: y = signed infinity, ovf=1.
  - Exponent <= 0: y = signed zero, unf=1 if the pre-round mantissa was nonzero.
  - Exact zero from x + (-x): +0. For (-0) + (-0): -0.
  - Either input NaN, or inf - inf: y = canonical NaN {0, all-ones, 1 followed by zeros}, nan=1, ovf=0.
  - Infinity input otherwise: y = that infinity (correct sign), ovf=0.
- Flags are mutually exclusive and travel with their result.

Test Plan:
- Default params, x1=0x3F800000, x2=0x3F800000, sub=0 → after 3 cycles y=0x40000000, all flags 0.
- x1=0x3FC00000, x2=0x3FC00000, sub=1 → y=0x00000000 (+0). Also x1=x2=0x80000000, sub=0 → y=0x80000000.
- x1=0x3F800000, x2=0x33800000 (exact half-ulp tie) → y=0x3F800000. With x2=0x33800001 → y=0x3F800001.
- x1=x2=0x7F7FFFFF → y=0x7F800000, ovf=1. x1=0x7F800000, x2=0x7F800000, sub=1 → y=0x7FC00000, nan=1.
- Stream of 6 back-to-back operand pairs, with out_ready=0 for cycles 4..8 → in_ready=0 whenever out_valid && !out_ready. All 6 results emerge in order, unchanged, with no loss or duplicate.
- rstn pulsed low for 1 cycle with 2 results in flight → out_valid=0 immediately. The next accepted pair appears 3 cycles after acceptance. Repeat the 1.0+1.0 check with EXP_W=5, MAN_W=10: 0x3C00+0x3C00 → 0x4000.

Source files
------------

// File: rtl/fadd_pipe.sv
// rtl/fadd_pipe.sv - 3-stage pipelined floating-point adder/subtractor with RNE rounding
// Stages: unpack/align -> add -> normalise/round/pack; one global enable stalls all stages.
module fadd_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int W     = EXP_W + MAN_W + 1
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] x1,
  input  logic [W-1:0] x2,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] y,
  output logic         ovf,
  output logic         unf,
  output logic         nan
);
  // aligned mantissa: hidden bit, stored mantissa, guard, round, sticky
  localparam int MX = MAN_W + 4;
  localparam int ES = EXP_W + 8;
  localparam int SW = $clog2(MX + 1);
  localparam logic [EXP_W-1:0] EMAX   = '1;
  localparam logic [ES-1:0]    EMAX_X = {{(ES-EXP_W){1'b0}}, EMAX};
  localparam logic [W-1:0]     QNAN   = {1'b0, EMAX, 1'b1, {(MAN_W-1){1'b0}}};

  logic en;
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  logic             a_s, b_s, a_z, b_z, a_inf, b_inf, a_nan, b_nan, swap, sticky;
  logic [W-2:0]     a_mag, b_mag, big_mag, sml_mag;
  logic [EXP_W-1:0] big_e, sml_e;
  logic [MX-1:0]    big_m, sml_m, sml_sh, sml_al;
  logic [SW-1:0]    shamt;
  int               ed;

  always_comb begin
    a_s   = x1[W-1];
    b_s   = x2[W-1] ^ sub;
    a_z   = x1[W-2:MAN_W] == '0;
    b_z   = x2[W-2:MAN_W] == '0;
    a_inf = (x1[W-2:MAN_W] == EMAX) && (x1[MAN_W-1:0] == '0);
    b_inf = (x2[W-2:MAN_W] == EMAX) && (x2[MAN_W-1:0] == '0);
    a_nan = (x1[W-2:MAN_W] == EMAX) && (x1[MAN_W-1:0] != '0);
    b_nan = (x2[W-2:MAN_W] == EMAX) && (x2[MAN_W-1:0] != '0);
    a_mag = a_z ? '0 : x1[W-2:0];
    b_mag = b_z ? '0 : x2[W-2:0];
    swap    = b_mag > a_mag;
    big_mag = swap ? b_mag : a_mag;
    sml_mag = swap ? a_mag : b_mag;
    big_e   = big_mag[W-2:MAN_W];
    sml_e   = sml_mag[W-2:MAN_W];
    big_m   = {|big_e, big_mag[MAN_W-1:0], 3'b000};
    sml_m   = {|sml_e, sml_mag[MAN_W-1:0], 3'b000};
    ed      = int'(big_e) - int'(sml_e);
    shamt   = (ed > MX - 1) ? SW'(MX - 1) : SW'(ed);
    sml_sh  = sml_m >> shamt;
    sticky  = 1'b0;
    for (int i = 0; i < MX; i++) begin
      if ((i < int'(shamt)) && sml_m[i]) sticky = 1'b1;
    end
    sml_al = {sml_sh[MX-1:1], sml_sh[0] | sticky};
  end

  logic             v1, s1_sign, s1_op, s1_nan, s1_inf, s1_inf_s, s1_zs;
  logic [EXP_W-1:0] s1_e;
  logic [MX-1:0]    s1_big, s1_sml;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      v1 <= 1'b0; s1_sign <= 1'b0; s1_op <= 1'b0; s1_nan <= 1'b0;
      s1_inf <= 1'b0; s1_inf_s <= 1'b0; s1_zs <= 1'b0;
      s1_e <= '0; s1_big <= '0; s1_sml <= '0;
    end else if (en) begin
      v1       <= in_valid;
      s1_sign  <= swap ? b_s : a_s;
      s1_op    <= a_s ^ b_s;
      s1_nan   <= a_nan || b_nan || (a_inf && b_inf && (a_s != b_s));
      s1_inf   <= a_inf || b_inf;
      s1_inf_s <= a_inf ? a_s : b_s;
      // exact zero is -0 only when both operands are negative zeros
      s1_zs    <= a_s & b_s;
      s1_e     <= big_e;
      s1_big   <= big_m;
      s1_sml   <= sml_al;
    end
  end

  logic             v2, s2_sign, s2_nan, s2_inf, s2_inf_s, s2_zs;
  logic [EXP_W-1:0] s2_e;
  logic [MX:0]      s2_sum;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      v2 <= 1'b0; s2_sign <= 1'b0; s2_nan <= 1'b0; s2_inf <= 1'b0;
      s2_inf_s <= 1'b0; s2_zs <= 1'b0; s2_e <= '0; s2_sum <= '0;
    end else if (en) begin
      v2       <= v1;
      s2_sign  <= s1_sign;
      s2_nan   <= s1_nan;
      s2_inf   <= s1_inf;
      s2_inf_s <= s1_inf_s;
      s2_zs    <= s1_zs;
      s2_e     <= s1_e;
      s2_sum   <= s1_op ? ({1'b0, s1_big} - {1'b0, s1_sml})
                        : ({1'b0, s1_big} + {1'b0, s1_sml});
    end
  end

  logic                 found, rup, ovf_d, unf_d, nan_d;
  logic [SW-1:0]        lz;
  logic [MX-1:0]        nrm;
  logic [MAN_W+1:0]     rnd;
  logic [MAN_W-1:0]     man_r;
  logic signed [ES-1:0] e_base, e_n;
  logic [W-1:0]         y_d;

  always_comb begin
    lz    = '0;
    found = 1'b0;
    for (int i = MX - 1; i >= 0; i--) begin
      if (!found) begin
        if (s2_sum[i]) found = 1'b1;
        else           lz    = lz + SW'(1);
      end
    end
    e_base = {{(ES-EXP_W){1'b0}}, s2_e};
    if (s2_sum[MX]) begin
      nrm = {s2_sum[MX:2], s2_sum[1] | s2_sum[0]};
      e_n = e_base + ES'(1);
    end else begin
      nrm = s2_sum[MX-1:0] << lz;
      e_n = e_base - {{(ES-SW){1'b0}}, lz};
    end
    rup = nrm[2] & (nrm[1] | nrm[0] | nrm[3]);
    rnd = {1'b0, nrm[MX-1:3]} + {{(MAN_W+1){1'b0}}, rup};
    if (rnd[MAN_W+1]) begin
      man_r = rnd[MAN_W:1];
      e_n   = e_n + ES'(1);
    end else begin
      man_r = rnd[MAN_W-1:0];
    end

    y_d   = '0;
    ovf_d = 1'b0;
    unf_d = 1'b0;
    nan_d = 1'b0;
    if (s2_nan) begin
      y_d   = QNAN;
      nan_d = 1'b1;
    end else if (s2_inf) begin
      y_d = {s2_inf_s, EMAX, {MAN_W{1'b0}}};
    end else if (s2_sum == '0) begin
      y_d = {s2_zs, {(W-1){1'b0}}};
    end else if (!e_n[ES-1] && ($unsigned(e_n) >= EMAX_X)) begin
      y_d   = {s2_sign, EMAX, {MAN_W{1'b0}}};
      ovf_d = 1'b1;
    end else if (e_n[ES-1] || (e_n == '0)) begin
      y_d   = {s2_sign, {(W-1){1'b0}}};
      unf_d = 1'b1;
    end else begin
      y_d = {s2_sign, e_n[EXP_W-1:0], man_r};
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid <= 1'b0; y <= '0; ovf <= 1'b0; unf <= 1'b0; nan <= 1'b0;
    end else if (en) begin
      out_valid <= v2;
      y         <= y_d;
      ovf       <= ovf_d;
      unf       <= unf_d;
      nan       <= nan_d;
    end
  end
endmodule
